// File: rtl/mlp_pkg.sv
// Shared constants and state encoding for the MLP image front end.
package mlp_pkg;
    localparam int NUM_IMAGES = 1797;
    localparam int IMAGE_SIZE = 65;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 17;
    localparam int IDX_W      = 11;
    localparam int PIXELS     = IMAGE_SIZE - 1;
    localparam int CNT_W      = $clog2(IMAGE_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {data, last} between the ROM return path and the pixel port.
module fetch_skid_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_last,
    output logic [1:0]   occ
);
    logic [W-1:0] d1;
    logic         l1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            head_last <= 1'b0;
            d1        <= '0;
            l1        <= 1'b0;
            occ       <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        d1 <= push_data;
                        l1 <= push_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= d1;
                    head_last <= l1;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        head_data <= d1;
                        head_last <= l1;
                        d1        <= push_data;
                        l1        <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/image_fetch_ctrl.sv
// Reads one image from the image ROM, streams its pixels and latches its label.
// IMG_AUTO_NEXT_EN: walk images with an internal pointer instead of img_idx.
module image_fetch_ctrl
    import mlp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  img_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rom_ren,
    output logic [ADDR_W-1:0] rom_radd,
    input  logic [DATA_W-1:0] rom_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [DATA_W-1:0] px_data,
    output logic              px_last,
    output logic [DATA_W-1:0] label,
    output logic              label_valid
);
    localparam logic [ADDR_W-1:0] SIZE_A  = ADDR_W'(IMAGE_SIZE);
    localparam logic [CNT_W-1:0]  LAST_RD = CNT_W'(IMAGE_SIZE - 1);
    localparam logic [CNT_W-1:0]  LAST_PX = CNT_W'(PIXELS - 1);
    localparam logic [CNT_W-1:0]  LBL_TAG = CNT_W'(PIXELS);

    fetch_state_e      state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  rtag;
    logic              rvalid;
    logic              px_done;
    logic [1:0]        occ;
    logic              pop;
    logic              push;
    logic              lbl_cap;
    logic              last_xfer;
    logic              go_done;
    logic [IDX_W-1:0]  sel_idx;
    logic              idx_ok;

`ifdef IMG_AUTO_NEXT_EN
    logic [IDX_W-1:0] ptr;

    assign sel_idx = ptr;
    assign idx_ok  = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == DONE) begin
            ptr <= (ptr == IDX_W'(NUM_IMAGES - 1)) ? '0 : ptr + 1'b1;
        end
    end
`else
    assign sel_idx = img_idx;
    assign idx_ok  = img_idx < IDX_W'(NUM_IMAGES);
`endif

    assign px_valid  = occ != 2'd0;
    assign pop       = px_valid && px_ready;
    assign push      = rvalid && (rtag != LBL_TAG);
    assign lbl_cap   = rvalid && (rtag == LBL_TAG);
    assign last_xfer = pop && px_last;
    assign go_done   = (px_done || last_xfer) && (label_valid || lbl_cap);

    // Credit the pop of this cycle so a full-rate stream keeps one read per cycle.
    assign rom_ren  = (state == FETCH) &&
                      (3'(occ) + 3'(rvalid) < 3'd2 + 3'(pop));
    assign rom_radd = rom_ren ? base + ADDR_W'(rd_cnt) : '0;

    fetch_skid_buf #(
        .W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (rom_data),
        .push_last (rtag == LAST_PX),
        .pop       (pop),
        .head_data (px_data),
        .head_last (px_last),
        .occ       (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            base        <= '0;
            rd_cnt      <= '0;
            rtag        <= '0;
            rvalid      <= 1'b0;
            px_done     <= 1'b0;
            label       <= '0;
            label_valid <= 1'b0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            rvalid <= rom_ren;
            rtag   <= rd_cnt;
            if (lbl_cap) begin
                label       <= rom_data;
                label_valid <= 1'b1;
            end
            if (last_xfer) begin
                px_done <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start && idx_ok) begin
                        base        <= ADDR_W'(sel_idx) * SIZE_A;
                        rd_cnt      <= '0;
                        label_valid <= 1'b0;
                        px_done     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= FETCH;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                FETCH: begin
                    if (rom_ren) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST_RD) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (go_done) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_image_fetch_ctrl.sv
// Directed bench for image_fetch_ctrl with a registered-read ROM model.
module tb_image_fetch_ctrl;
    localparam int TOTAL = 1797 * 65;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] img_idx = '0;
    logic        busy, done, err, rom_ren;
    logic [16:0] rom_radd;
    logic [15:0] rom_data = '0;
    logic        px_valid, px_last, label_valid;
    logic        px_ready = 1'b0;
    logic [15:0] px_data, label;

    logic [15:0] mem [0:TOTAL-1];

    int ncomp = 0;
    int nfail = 0;
    int cyc = 0;
    int t0 = 0;
    bit rand_rdy = 1'b0;

    int cur_base = 0;
    int nreads, amin, amax, out_cnt, max_out, stab_bad;
    int first_k, done_k, done_cnt;
    bit prev_lbl, stall_prev;
    logic [15:0] stall_data;
    logic [15:0] got_d[$];
    bit          got_l[$];

    image_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .img_idx     (img_idx),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rom_ren     (rom_ren),
        .rom_radd    (rom_radd),
        .rom_data    (rom_data),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_data     (px_data),
        .px_last     (px_last),
        .label       (label),
        .label_valid (label_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_ren) rom_data <= mem[rom_radd];
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) px_ready = 1'($urandom_range(0, 1));
    end

    function automatic logic [15:0] romval(input int i);
        return 16'((i * 37 + 11) ^ (i >> 4));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            out_cnt    = 0;
            prev_lbl   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (rom_ren) begin
                nreads++;
                if (int'(rom_radd) < amin) amin = int'(rom_radd);
                if (int'(rom_radd) > amax) amax = int'(rom_radd);
            end
            out_cnt = out_cnt + int'(rom_ren) - int'(px_valid && px_ready)
                      - int'(prev_lbl);
            if (out_cnt > max_out) max_out = out_cnt;
            prev_lbl = rom_ren && (int'(rom_radd) == cur_base + 64);
            if (stall_prev && !(px_valid && px_data === stall_data)) stab_bad++;
            stall_prev = px_valid && !px_ready;
            stall_data = px_data;
            if (px_valid && first_k < 0) first_k = cyc - t0;
            if (px_valid && px_ready) begin
                got_d.push_back(px_data);
                got_l.push_back(px_last);
            end
            if (done) begin
                done_cnt++;
                done_k = cyc - t0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic init_mon(input int base);
        cur_base = base;
        nreads   = 0;
        amin     = 32'h7fffffff;
        amax     = -1;
        max_out  = 0;
        stab_bad = 0;
        first_k  = -1;
        done_k   = -1;
        got_d.delete();
        got_l.delete();
    endtask

    task automatic start_img(input logic [10:0] idx);
        @(posedge clk);
        #1;
        start   = 1'b1;
        img_idx = idx;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget, input int poke);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == poke);
            if (n == poke) img_idx = 11'd7;
        end
        start = 1'b0;
        chk({tag, "_done_in_time"}, 32'(n < budget), 1);
    endtask

    task automatic check_image(input string t, input int base);
        int bad = 0;
        int lbad = 0;
        chk({t, "_count"}, got_d.size(), 64);
        for (int k = 0; k < got_d.size() && k < 64; k++) begin
            if (got_d[k] !== romval(base + k)) bad++;
            if (got_l[k] != (k == 63)) lbad++;
        end
        chk({t, "_data_bad"}, bad, 0);
        chk({t, "_last_bad"}, lbad, 0);
        chk({t, "_label"}, label, romval(base + 64));
        chk({t, "_label_valid"}, label_valid, 1);
        chk({t, "_reads"}, nreads, 65);
        chk({t, "_amin"}, amin, base);
        chk({t, "_amax"}, amax, base + 64);
        chk({t, "_outstanding_le2"}, 32'(max_out <= 2), 1);
        chk({t, "_stable"}, stab_bad, 0);
        chk({t, "_busy_after"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < TOTAL; i++) mem[i] = romval(i);
        done_cnt = 0;
        init_mon(0);
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ren", rom_ren, 0);
        chk("rst_radd", rom_radd, 0);
        chk("rst_pxv", px_valid, 0);
        chk("rst_pxd", px_data, 0);
        chk("rst_pxl", px_last, 0);
        chk("rst_label", label, 0);
        chk("rst_lv", label_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef IMG_AUTO_NEXT_EN
        px_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            init_mon(j * 65);
            start_img(11'd1797);
            chk("auto_err", err, 0);
            chk("auto_busy", busy, 1);
            wait_done("auto", 200, 0);
            check_image("auto", j * 65);
        end
`else
        // full-rate stream of image 0
        px_ready = 1'b1;
        init_mon(0);
        start_img(11'd0);
        chk("i0_busy", busy, 1);
        chk("i0_ren", rom_ren, 1);
        chk("i0_radd", rom_radd, 0);
        wait_done("i0", 200, 0);
        chk("i0_first_valid", first_k, 2);
        chk("i0_done_k", done_k, 66);
        chk("i0_done_cnt", done_cnt, 1);
        check_image("i0", 0);

        // last image in ROM
        init_mon(116740);
        start_img(11'd1796);
        wait_done("i1796", 200, 0);
        chk("i1796_done_k", done_k, 66);
        check_image("i1796", 116740);

        // out-of-range index
        init_mon(0);
        start_img(11'd1797);
        chk("bad_err", err, 1);
        chk("bad_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("bad_err_pulse", err, 0);
        chk("bad_busy2", busy, 0);
        chk("bad_reads", nreads, 0);

        // backpressure held low: two reads then stall
        px_ready = 1'b0;
        init_mon(650);
        start_img(11'd10);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_reads", nreads, 2);
        chk("stall_pxv", px_valid, 1);
        chk("stall_pxd", px_data, romval(650));
        px_ready = 1'b1;
        wait_done("stall", 300, 0);
        check_image("stall", 650);

        // random ready, plus a start while busy that must be ignored
        rand_rdy = 1'b1;
        init_mon(195);
        start_img(11'd3);
        wait_done("rand", 1000, 20);
        rand_rdy = 1'b0;
        px_ready = 1'b1;
        check_image("rand", 195);
        repeat (3) @(posedge clk);
        #1;
        chk("rand_no_restart", busy, 0);

        // reset in the middle of image 5
        begin
            int n = 0;
            int dc;
            init_mon(325);
            start_img(11'd5);
            while (got_d.size() < 30 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("mid_reach30", got_d.size(), 30);
            dc = done_cnt;
            rst_n = 1'b0;
            #1;
            chk("mid_busy", busy, 0);
            chk("mid_ren", rom_ren, 0);
            chk("mid_radd", rom_radd, 0);
            chk("mid_pxv", px_valid, 0);
            chk("mid_pxd", px_data, 0);
            chk("mid_label", label, 0);
            chk("mid_lv", label_valid, 0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("mid_no_done", done_cnt, dc);
            chk("mid_idle", busy, 0);
        end
        init_mon(130);
        start_img(11'd2);
        wait_done("after_rst", 200, 0);
        chk("after_rst_done_k", done_k, 66);
        check_image("after_rst", 130);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
